// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared types and constants for the fetch/LSU memory port arbiter: lock-state
//   encodings, port-select constants, default widths and the starvation-counter
//   width helper.
//   Ports: none (package).
package mem_port_arbiter_pkg;

   // Lock state of the shared memory port.
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StLockI = 2'd1,
      StLockD = 2'd2
   } lock_state_e;

   // Which requester currently drives the memory port.
   typedef enum logic [1:0] {
      SelNone = 2'd0,
      SelI    = 2'd1,
      SelD    = 2'd2
   } port_sel_e;

   localparam int unsigned DefAddrWidth = 32;
   localparam int unsigned DefDataWidth = 32;

   // Bits needed to hold 0..limit inclusive.
   function automatic int unsigned starve_cnt_width(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter
//   Saturating counter of data completions seen while fetch is waiting.
//   Clear wins over increment; the count holds once it reaches LIMIT.
//   Ports:
//     clk         - clock
//     rst_n       - asynchronous active-low reset
//     inc_i       - count one data completion
//     clr_i       - return count to zero
//     at_limit_o  - count equals LIMIT
module arb_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_limit_o
);

   localparam int unsigned CntW = starve_cnt_width(LIMIT);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign at_limit_o = (cnt_q == CntW'(LIMIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !at_limit_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported valid/ready memory between the fetch stage (i_*)
//   and the load/store unit (d_*). Data has priority; a grant stays locked to
//   its side until the memory completes or that side drops valid. All paths
//   are combinational, so the block adds no latency.
//   Optional starvation guard: define MEM_ARB_STARVE_GUARD_EN to grant fetch
//   after STARVE_LIMIT consecutive data completions while fetch waits.
//   Ports:
//     clk, rst_n                       - clock, asynchronous active-low reset
//     i_valid_i/i_ready_o/i_addr_i/i_rdata_o            - fetch port
//     d_valid_i/d_ready_o/d_addr_i/d_wdata_i/d_we_i/d_rdata_o - data port
//     mem_valid_o/mem_ready_i/mem_addr_o/mem_wdata_o/mem_we_o/mem_rdata_i
//                                      - physical memory port
//     grant_d_o                        - data side currently selected
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
   parameter int unsigned DATA_WIDTH   = DefDataWidth,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // Fetch side
   input  logic                  i_valid_i,
   output logic                  i_ready_o,
   input  logic [ADDR_WIDTH-1:0] i_addr_i,
   output logic [DATA_WIDTH-1:0] i_rdata_o,
   // Data side
   input  logic                  d_valid_i,
   output logic                  d_ready_o,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   input  logic [3:0]            d_we_i,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   // Memory side
   output logic                  mem_valid_o,
   input  logic                  mem_ready_i,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [3:0]            mem_we_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   // Debug
   output logic                  grant_d_o
);

   lock_state_e state_q, state_d;
   port_sel_e   sel;
   logic        force_fetch;

   // Effective selection. A lock only holds while its owner keeps valid high,
   // so an abandoned lock falls through to fresh arbitration in the same cycle.
   always_comb begin
      sel = SelNone;
      if (state_q == StLockI && i_valid_i) begin
         sel = SelI;
      end else if (state_q == StLockD && d_valid_i) begin
         sel = SelD;
      end else if (d_valid_i && !force_fetch) begin
         sel = SelD;
      end else if (i_valid_i) begin
         sel = SelI;
      end
   end

   always_comb begin
      mem_valid_o = (sel != SelNone) && rst_n;
      grant_d_o   = (sel == SelD) && rst_n;
      mem_addr_o  = (sel == SelD) ? d_addr_i : i_addr_i;
      mem_wdata_o = (sel == SelD) ? d_wdata_i : '0;
      mem_we_o    = (grant_d_o && mem_valid_o) ? d_we_i : 4'h0;
      i_ready_o   = mem_ready_i && mem_valid_o && (sel == SelI) && i_valid_i;
      d_ready_o   = mem_ready_i && mem_valid_o && (sel == SelD) && d_valid_i;
      i_rdata_o   = mem_rdata_i;
      d_rdata_o   = mem_rdata_i;
   end

   // Lock onto whichever side is stalled by the memory; otherwise re-arbitrate.
   always_comb begin
      state_d = StIdle;
      if (mem_valid_o && !mem_ready_i) begin
         state_d = (sel == SelD) ? StLockD : StLockI;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic starve_at_limit;

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_counter (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (d_ready_o && i_valid_i),
      .clr_i      (i_ready_o || !i_valid_i),
      .at_limit_o (starve_at_limit)
   );

   assign force_fetch = i_valid_i && starve_at_limit;
`else
   logic unused_starve_limit;

   assign unused_starve_limit = (STARVE_LIMIT != 0);
   assign force_fetch         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Each step drives inputs just after a
//   rising edge, pushes the expected outputs to a scoreboard queue and pops /
//   compares them on the following falling edge.
module tb_mem_port_arbiter;

   localparam int unsigned Limit = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit Guard = 1'b1;
`else
   localparam bit Guard = 1'b0;
`endif

   typedef struct packed {
      logic        care;  // compare address / write data
      logic        mv;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      logic        ir;
      logic        dr;
      logic        gd;
      logic [31:0] rdata;
   } exp_t;

   logic        clk, rst_n;
   logic        i_valid, i_ready;
   logic [31:0] i_addr, i_rdata;
   logic        d_valid, d_ready;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_we;
   logic        mem_valid, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_we;
   logic        grant_d;

   int total = 0;
   int bad   = 0;
   exp_t sb[$];

   mem_port_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (Limit)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid_i   (i_valid),
      .i_ready_o   (i_ready),
      .i_addr_i    (i_addr),
      .i_rdata_o   (i_rdata),
      .d_valid_i   (d_valid),
      .d_ready_o   (d_ready),
      .d_addr_i    (d_addr),
      .d_wdata_i   (d_wdata),
      .d_we_i      (d_we),
      .d_rdata_o   (d_rdata),
      .mem_valid_o (mem_valid),
      .mem_ready_i (mem_ready),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_we_o    (mem_we),
      .mem_rdata_i (mem_rdata),
      .grant_d_o   (grant_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ex(input logic care, input logic mv, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] we,
                               input logic ir, input logic dr, input logic gd);
      exp_t e;
      e.care  = care;
      e.mv    = mv;
      e.addr  = addr;
      e.wdata = wdata;
      e.we    = we;
      e.ir    = ir;
      e.dr    = dr;
      e.gd    = gd;
      e.rdata = mem_rdata;
      return e;
   endfunction

   task automatic drv(input logic iv, input logic [31:0] ia, input logic dv,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dwe,
                      input logic mr, input logic [31:0] mrd);
      i_valid   = iv;
      i_addr    = ia;
      d_valid   = dv;
      d_addr    = da;
      d_wdata   = dwd;
      d_we      = dwe;
      mem_ready = mr;
      mem_rdata = mrd;
   endtask

   task automatic step(input string tag, input exp_t e);
      exp_t x;
      sb.push_back(e);
      @(negedge clk);
      x = sb.pop_front();
      check({tag, ".mem_valid"}, {31'd0, mem_valid}, {31'd0, x.mv});
      check({tag, ".mem_we"}, {28'd0, mem_we}, {28'd0, x.we});
      check({tag, ".i_ready"}, {31'd0, i_ready}, {31'd0, x.ir});
      check({tag, ".d_ready"}, {31'd0, d_ready}, {31'd0, x.dr});
      check({tag, ".grant_d"}, {31'd0, grant_d}, {31'd0, x.gd});
      check({tag, ".i_rdata"}, i_rdata, x.rdata);
      check({tag, ".d_rdata"}, d_rdata, x.rdata);
      if (x.care) begin
         check({tag, ".mem_addr"}, mem_addr, x.addr);
         check({tag, ".mem_wdata"}, mem_wdata, x.wdata);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      bit fetch_turn;

      // Reset with both sides requesting: all handshake outputs held low.
      rst_n = 1'b0;
      drv(1, 32'h100, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h13);
      step("reset", ex(0, 0, 0, 0, 4'h0, 0, 0, 0));

      // Fetch only, same-cycle memory.
      rst_n = 1'b1;
      drv(1, 32'h100, 0, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h13);
      step("fetch_only", ex(1, 1, 32'h100, 0, 4'h0, 1, 0, 0));

      // Contention: data wins, fetch completes next cycle.
      drv(1, 32'h104, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h55);
      step("contend_d", ex(1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 0, 1, 1));
      drv(1, 32'h104, 0, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 32'h66);
      step("contend_i", ex(1, 1, 32'h104, 0, 4'h0, 1, 0, 0));

      // Lock on fetch for three stalled cycles while data arrives.
      drv(1, 32'h200, 0, 32'h3000, 32'h12345678, 4'h0, 0, 32'h77);
      step("lock_c1", ex(1, 1, 32'h200, 0, 4'h0, 0, 0, 0));
      drv(1, 32'h200, 1, 32'h3000, 32'h12345678, 4'h0, 0, 32'h77);
      step("lock_c2", ex(1, 1, 32'h200, 0, 4'h0, 0, 0, 0));
      step("lock_c3", ex(1, 1, 32'h200, 0, 4'h0, 0, 0, 0));
      drv(1, 32'h200, 1, 32'h3000, 32'h12345678, 4'h0, 1, 32'h88);
      step("lock_c4", ex(1, 1, 32'h200, 0, 4'h0, 1, 0, 0));
      drv(0, 32'h200, 1, 32'h3000, 32'h12345678, 4'h0, 1, 32'h99);
      step("lock_c5", ex(1, 1, 32'h3000, 32'h12345678, 4'h0, 0, 1, 1));

      // Redirect during a fetch lock: new address seen at once, grant held.
      drv(1, 32'h40, 0, 32'h4000, 32'hA5A5A5A5, 4'h3, 0, 32'h1);
      step("redir_lock", ex(1, 1, 32'h40, 0, 4'h0, 0, 0, 0));
      drv(1, 32'h80, 1, 32'h4000, 32'hA5A5A5A5, 4'h3, 0, 32'h2);
      step("redir_new", ex(1, 1, 32'h80, 0, 4'h0, 0, 0, 0));
      drv(1, 32'h80, 1, 32'h4000, 32'hA5A5A5A5, 4'h3, 1, 32'h3);
      step("redir_done", ex(1, 1, 32'h80, 0, 4'h0, 1, 0, 0));
      drv(0, 32'h80, 1, 32'h4000, 32'hA5A5A5A5, 4'h3, 1, 32'h4);
      step("redir_data", ex(1, 1, 32'h4000, 32'hA5A5A5A5, 4'h3, 0, 1, 1));

      // Abandon a data lock: fetch selected in the same cycle.
      drv(0, 32'h300, 1, 32'h5000, 32'h0, 4'h0, 0, 32'h5);
      step("aband_lockd", ex(1, 1, 32'h5000, 0, 4'h0, 0, 0, 1));
      drv(1, 32'h300, 0, 32'h5000, 32'h0, 4'h0, 1, 32'h6);
      step("aband_fetch", ex(1, 1, 32'h300, 0, 4'h0, 1, 0, 0));

      // Reset in the middle of a data lock.
      drv(1, 32'h600, 1, 32'h6000, 32'hCAFEF00D, 4'hF, 0, 32'h7);
      step("rstlock_a", ex(1, 1, 32'h6000, 32'hCAFEF00D, 4'hF, 0, 0, 1));
      rst_n = 1'b0;
      step("rstlock_b", ex(0, 0, 0, 0, 4'h0, 0, 0, 0));

      // Starvation: data continuously valid, fetch waiting, memory always ready.
      rst_n = 1'b1;
      drv(1, 32'h600, 1, 32'h7000, 32'hBEEF0000, 4'h0, 1, 32'h8);
      cnt = 0;
      for (int k = 0; k < 2 * Limit + 2; k++) begin
         fetch_turn = Guard && (cnt == Limit);
         if (fetch_turn) begin
            step($sformatf("starve%0d", k), ex(1, 1, 32'h600, 0, 4'h0, 1, 0, 0));
            cnt = 0;
         end else begin
            step($sformatf("starve%0d", k), ex(1, 1, 32'h7000, 32'hBEEF0000, 4'h0, 0, 1, 1));
            if (cnt < Limit) cnt++;
         end
      end

      // Idle.
      drv(0, 32'h0, 0, 32'h0, 32'h0, 4'hF, 1, 32'h9);
      step("idle", ex(1, 0, 32'h0, 0, 4'h0, 0, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
